// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers.
// State encoding, counter width and per-boundary payload structs.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int FLUSH_CNT_W = 16;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } idex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] store_val;
    logic [4:0]      rd;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_val;
    logic [4:0]      rd;
    logic            reg_wr;
  } memwb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall, flush and skid.
// Ports: CLK, nRST, en, flush, in_*, out_*, occupancy, flush_cnt.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  pipe_state_t       state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;
  logic              cnt_sat;

  assign out_valid = (state != EMPTY) & en;
  assign out_data  = main_q;

  // Skid mode keeps in_ready off the out_ready path entirely.
  generate
    if (SKID_EN) begin : g_skid_rdy
      assign in_ready = en & (state != SKID);
    end else begin : g_flat_rdy
      assign in_ready = en & ((state == EMPTY) | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cnt_sat  = &flush_cnt;

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      main_q    <= NOP_DATA;
      skid_q    <= NOP_DATA;
      flush_cnt <= '0;
    end else if (en) begin
      if (flush) begin
        state  <= EMPTY;
        main_q <= NOP_DATA;
        // Only flushes that actually drop something are counted.
        if (((state != EMPTY) | in_fire) & ~cnt_sat)
          flush_cnt <= flush_cnt + 1'b1;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              state  <= FULL;
              main_q <= in_data;
            end
          end
          FULL: begin
            if (in_fire & out_fire) begin
              main_q <= in_data;
            end else if (out_fire) begin
              state  <= EMPTY;
              main_q <= NOP_DATA;
            end else if (in_fire & SKID_EN) begin
              state  <= SKID;
              skid_q <= in_data;
            end
          end
          SKID: begin
            // Head leaves; the younger skid entry moves up.
            if (out_fire) begin
              state  <= FULL;
              main_q <= skid_q;
            end
          end
          default: begin
            state  <= EMPTY;
            main_q <= NOP_DATA;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Covers reset, streaming, skid, stall, flush, saturation, no-skid mode.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        CLK;
  logic        nRST;

  logic        en0, flush0, iv0, ir0, ov0, or0;
  logic [31:0] id0, od0;
  logic [1:0]  occ0;
  logic [15:0] fc0;

  logic        en1, flush1, iv1, ir1, ov1, or1;
  logic [31:0] id1, od1;
  logic [1:0]  occ1;
  logic [15:0] fc1;

  int checks;
  int errors;

  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .NOP_DATA('0)) u_skid (
    .CLK(CLK), .nRST(nRST), .en(en0), .flush(flush0),
    .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(or0),
    .occupancy(occ0), .flush_cnt(fc0)
  );

  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .NOP_DATA('0)) u_flat (
    .CLK(CLK), .nRST(nRST), .en(en1), .flush(flush1),
    .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1),
    .occupancy(occ1), .flush_cnt(fc1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    en0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b0;
    en1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    #1;

    // Load one entry, then reset mid-cycle with input still offered.
    iv0 = 1'b1; id0 = 32'h99;
    tick();
    chk("load_occ", 32'(occ0), 32'd1);
    chk("load_data", od0, 32'h99);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_data", od0, 32'h0);
    chk("rst_occ", 32'(occ0), 32'd0);
    chk("rst_fcnt", 32'(fc0), 32'd0);
    iv0 = 1'b0;
    nRST = 1'b1;
    #1;
    chk("rst_ready", 32'(ir0), 32'd1);

    // Streaming at full rate.
    or0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iv0 = 1'b1; id0 = 32'(i);
      #1;
      chk("strm_ready", 32'(ir0), 32'd1);
      tick();
      chk("strm_data", od0, 32'(i));
      chk("strm_valid", 32'(ov0), 32'd1);
      chk("strm_occ", 32'(occ0), 32'd1);
    end
    iv0 = 1'b0;
    tick();
    chk("strm_drain", 32'(ov0), 32'd0);
    chk("strm_nop", od0, 32'h0);

    // Backpressure into the skid slot.
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 32'hA;
    tick();
    id0 = 32'hB;
    #1;
    chk("bp_rdy_b", 32'(ir0), 32'd1);
    tick();
    chk("bp_occ2", 32'(occ0), 32'd2);
    id0 = 32'hC;
    #1;
    chk("bp_rdy_c", 32'(ir0), 32'd0);
    tick();
    chk("bp_hold_occ", 32'(occ0), 32'd2);
    chk("bp_hold_head", od0, 32'hA);
    or0 = 1'b1;
    #1;
    chk("bp_rdy_indep", 32'(ir0), 32'd0);
    tick();
    chk("bp_out_b", od0, 32'hB);
    chk("bp_occ_b", 32'(occ0), 32'd1);
    tick();
    chk("bp_out_c", od0, 32'hC);
    iv0 = 1'b0;
    tick();
    chk("bp_empty", 32'(ov0), 32'd0);

    // Stall while full; flush and input are ignored.
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 32'h55;
    tick();
    en0 = 1'b0; id0 = 32'h66; flush0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_ready", 32'(ir0), 32'd0);
      chk("stl_valid", 32'(ov0), 32'd0);
      tick();
      chk("stl_occ", 32'(occ0), 32'd1);
      chk("stl_data", od0, 32'h55);
    end
    chk("stl_fcnt", 32'(fc0), 32'd0);
    en0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    #1;
    chk("stl_emit", od0, 32'h55);
    chk("stl_emit_v", 32'(ov0), 32'd1);
    tick();
    chk("stl_once", 32'(ov0), 32'd0);

    // Flush with two held entries and a live offer.
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 32'h11;
    tick();
    id0 = 32'h22;
    tick();
    chk("fl_occ2", 32'(occ0), 32'd2);
    id0 = 32'h77; flush0 = 1'b1;
    tick();
    chk("fl_occ", 32'(occ0), 32'd0);
    chk("fl_nop", od0, 32'h0);
    chk("fl_cnt1", 32'(fc0), 32'd1);
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    tick();
    chk("fl_no77", 32'(ov0), 32'd0);
    // Flush while full with an accepted offer.
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 32'h33;
    tick();
    id0 = 32'h77; flush0 = 1'b1;
    tick();
    chk("fl_cnt2", 32'(fc0), 32'd2);
    chk("fl_occ_b", 32'(occ0), 32'd0);
    iv0 = 1'b0;
    tick();
    chk("fl_idle", 32'(fc0), 32'd2);
    flush0 = 1'b0;

    // Saturate the flush counter.
    flush0 = 1'b1; iv0 = 1'b1; id0 = 32'h5A;
    for (int i = 0; i < 65537; i++) @(posedge CLK);
    #1;
    chk("sat_cnt", 32'(fc0), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(fc0), 32'hFFFF);
    flush0 = 1'b0; iv0 = 1'b0;

    // Single-entry mode.
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 32'hA;
    #1;
    chk("nsk_rdy0", 32'(ir1), 32'd1);
    tick();
    chk("nsk_occ1", 32'(occ1), 32'd1);
    id1 = 32'hB;
    #1;
    chk("nsk_rdy_full", 32'(ir1), 32'd0);
    tick();
    chk("nsk_occ_max", 32'(occ1), 32'd1);
    chk("nsk_head", od1, 32'hA);
    or1 = 1'b1;
    #1;
    chk("nsk_rdy_pass", 32'(ir1), 32'd1);
    tick();
    chk("nsk_out_b", od1, 32'hB);
    chk("nsk_occ_b", 32'(occ1), 32'd1);
    iv1 = 1'b0;
    tick();
    chk("nsk_empty", 32'(ov1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
